seq_masked_mem_bank: RTL and testbench
======================================

// Module: seq_masked_mem_bank
// PURPOSE
//  Parametrised multi-write-port memory with per-bit write masks, per-port enables,
//  registered read port and hardware clear sequencer. Generalises single word/bit
//  mem writes to N masked ports with defined collision and read-during-write rules.
//  Sits in elaboration regression set as canonical seq memory + FSM target.
// PARAMETERS
//  DATA_WIDTH   8               word width in bits
//  ADDR_WIDTH   4               address width
//  DEPTH        1<<ADDR_WIDTH   number of words (<= 2**ADDR_WIDTH)
//  NUM_WR       2               number of write ports (>= 1)
//  RD_BYPASS    1               1: same-cycle write forwarded to read; 0: old data
//  CLEAR_VALUE  '0              word value written by clear sweep
// PORTS
//  clk        in   1                      clock, all logic on posedge
//  rst        in   1                      synchronous reset, active-high
//  wr_en      in   NUM_WR                 per-port write enable
//  wr_addr    in   NUM_WR*ADDR_WIDTH      packed write addresses, port p at [p*AW +: AW]
//  wr_data    in   NUM_WR*DATA_WIDTH      packed write data
//  wr_mask    in   NUM_WR*DATA_WIDTH      packed per-bit mask, 1 = bit written
//  rd_en      in   1                      read request
//  rd_addr    in   ADDR_WIDTH             read address
//  clr_req    in   1                      pulse: start clear sweep
//  rd_data    out  DATA_WIDTH             registered read data
//  rd_valid   out  1                      rd_data updated this cycle
//  busy       out  1                      clear sweep in progress
// BEHAVIOUR
//  - FSM states IDLE, CLEAR. rst (highest priority) -> CLEAR, sweep ptr=0,
//    rd_data=0, rd_valid=0, busy=1. Memory contents not reset directly.
//  - CLEAR: mem[ptr] <= CLEAR_VALUE; ptr++ each cycle; after ptr==DEPTH-1 written
//    -> IDLE next cycle (sweep = DEPTH cycles). busy=1 throughout CLEAR.
//  - CLEAR: all wr_en, rd_en, clr_req ignored; rd_valid=0; rd_data holds.
//  - IDLE + clr_req -> CLEAR with ptr=0 next cycle; busy rises next cycle.
//  - rst asserted mid-sweep restarts sweep at ptr=0.
//  - Write (IDLE): for each p with wr_en[p], mem[a] <= (mem[a] & ~m) | (d & m).
//    Mask all-zero = no change. Effective next cycle.
//  - Collisions: ports on same address merge per bit; where masks overlap, highest
//    port index wins. Different addresses fully independent.
//  - Out-of-range (addr >= DEPTH): write dropped; read returns CLEAR_VALUE, rd_valid=1.
//  - Read: latency 1. rd_en=1 -> next cycle rd_data = word, rd_valid=1.
//    rd_en=0 -> rd_valid=0, rd_data holds previous value.
//  - Read-during-write same addr: RD_BYPASS=1 -> fully merged post-write word;
//    RD_BYPASS=0 -> pre-write word.
//  - No combinational path input -> output; all outputs registered.
// TESTING
//  1. rst 1 cycle -> busy=1 for exactly DEPTH (16) cycles; then read all addrs -> 8'h00.
//  2. port0 addr3 d=8'hAB m=8'hFF; next cycle rd addr3 -> rd_data=8'hAB, rd_valid=1.
//  3. mem[5]=8'hF0; port0 addr5 d=8'h0F m=8'h03, port1 addr5 d=8'hFF m=8'h01 same
//     cycle -> mem[5]=8'hF3 (bit0 from port1, bit1 from port0).
//  4. RD_BYPASS=1: mem[2]=8'h11, write addr2 8'h22 m=FF + rd addr2 same cycle -> 8'h22;
//     RD_BYPASS=0 build -> 8'h11.
//  5. clr_req mid-traffic, rst at sweep ptr=7 -> sweep restarts, busy 16 more cycles,
//     writes during busy dropped, all words = CLEAR_VALUE after.
//  6. rd_en=1 then rd_en=0 with rd_addr changing -> rd_valid 1 then 0, rd_data held.

Source files
------------

// File: rtl/seq_masked_mem_bank_if.sv
// Bus bundle for seq_masked_mem_bank: masked write ports, read port,
// clear request and status. The master drives requests, the slave (memory)
// returns registered read data and the busy flag.
interface seq_masked_mem_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WR     = 2
);
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_mask;
  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic                         clr_req;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         rd_valid;
  logic                         busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/seq_masked_mem_bank.sv
// Multi-write-port memory with per-bit write masks, a registered read port
// and a hardware clear sweep. Ports hitting the same word merge bit by bit,
// with the highest port index owning any overlapping mask bits.
module seq_masked_mem_bank #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    DEPTH       = 1 << ADDR_WIDTH,
  parameter int                    NUM_WR      = 2,
  parameter int                    RD_BYPASS   = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_masked_mem_bank_if.slave  bus
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam addr_t LAST_PTR = addr_t'(DEPTH - 1);

  state_t r_state;
  addr_t  r_ptr;
  word_t  r_mem [DEPTH];
  word_t  r_rdData;
  logic   r_rdValid;
  logic   r_busy;

  logic [NUM_WR-1:0] w_wrHit;
  word_t             w_merged [NUM_WR];
  word_t             w_rdWord;

  // Addresses at or beyond DEPTH are not backed by storage.
  function automatic logic inRange(input addr_t a);
    return int'(a) < DEPTH;
  endfunction

  function automatic addr_t portAddr(input int p);
    return bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic word_t portData(input int p);
    return bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic word_t portMask(input int p);
    return bus.wr_mask[p*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Per port, build the word as it looks after every port up to and including
  // this one has applied its mask; the highest-index port at an address thus
  // carries the complete merge, so its write wins the memory update.
  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      w_wrHit[p] = bus.wr_en[p] && inRange(portAddr(p));
    end
    for (int p = 0; p < NUM_WR; p++) begin
      w_merged[p] = inRange(portAddr(p)) ? r_mem[portAddr(p)] : CLEAR_VALUE;
      for (int q = 0; q <= p; q++) begin
        if (w_wrHit[q] && (portAddr(q) == portAddr(p))) begin
          w_merged[p] = (w_merged[p] & ~portMask(q)) | (portData(q) & portMask(q));
        end
      end
    end
  end

  // Read word, optionally with this cycle's writes folded in so a read of a
  // word being written returns the post-write value.
  always_comb begin
    w_rdWord = inRange(bus.rd_addr) ? r_mem[bus.rd_addr] : CLEAR_VALUE;
    if ((RD_BYPASS != 0) && inRange(bus.rd_addr)) begin
      for (int q = 0; q < NUM_WR; q++) begin
        if (w_wrHit[q] && (portAddr(q) == bus.rd_addr)) begin
          w_rdWord = (w_rdWord & ~portMask(q)) | (portData(q) & portMask(q));
        end
      end
    end
  end

  // Storage update: the sweep owns the array while clearing, otherwise the
  // enabled in-range ports write their merged words (later ports override).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_ptr] <= CLEAR_VALUE;
      end else begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_wrHit[p]) begin
            r_mem[portAddr(p)] <= w_merged[p];
          end
        end
      end
    end
  end

  // Control FSM with registered read outputs and busy flag; reset starts a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_ptr     <= '0;
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_rdValid <= 1'b0;
          if (r_ptr == LAST_PTR) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        IDLE: begin
          r_rdValid <= bus.rd_en;
          if (bus.rd_en) begin
            r_rdData <= w_rdWord;
          end
          if (bus.clr_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ptr     <= '0;
          r_rdValid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data  = r_rdData;
  assign bus.rd_valid = r_rdValid;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_seq_masked_mem_bank.sv
// Directed bench for seq_masked_mem_bank: one bypassing and one
// non-bypassing instance see the same stimulus; a vector table covers
// masked writes, collisions and read-during-write, and hand sequences
// cover the reset sweep, clear request and reset in mid-sweep.
module tb_seq_masked_mem_bank;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_masked_mem_bank_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WR(2)) bus0 ();
  seq_masked_mem_bank_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WR(2)) bus1 ();

  seq_masked_mem_bank #(.RD_BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  seq_masked_mem_bank #(.RD_BYPASS(0)) dutNb (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  assign bus1.wr_en   = bus0.wr_en;
  assign bus1.wr_addr = bus0.wr_addr;
  assign bus1.wr_data = bus0.wr_data;
  assign bus1.wr_mask = bus0.wr_mask;
  assign bus1.rd_en   = bus0.rd_en;
  assign bus1.rd_addr = bus0.rd_addr;
  assign bus1.clr_req = bus0.clr_req;

  typedef struct {
    logic [1:0] wrEn;
    logic [3:0] a0;
    logic [7:0] d0;
    logic [7:0] m0;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [7:0] m1;
    logic       rdEn;
    logic [3:0] rdAddr;
    logic       expValid;
    logic [7:0] expData;
    logic [7:0] expDataNb;
  } vec_t;

  vec_t vecs [20];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus0.wr_en   = v.wrEn;
    bus0.wr_addr = {v.a1, v.a0};
    bus0.wr_data = {v.d1, v.d0};
    bus0.wr_mask = {v.m1, v.m0};
    bus0.rd_en   = v.rdEn;
    bus0.rd_addr = v.rdAddr;
    bus0.clr_req = 1'b0;
  endtask

  task automatic idleInputs();
    bus0.wr_en   = '0;
    bus0.wr_addr = '0;
    bus0.wr_data = '0;
    bus0.wr_mask = '0;
    bus0.rd_en   = 1'b0;
    bus0.rd_addr = '0;
    bus0.clr_req = 1'b0;
  endtask

  // Counts the cycles busy stays high, the current sample included; inputs
  // are idled the moment busy falls so nothing leaks into IDLE.
  task automatic countBusy(input string name, input logic checkRd);
    int n;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (checkRd) checkOutput({name, "_rdvalid_low"}, {7'd0, bus0.rd_valid}, 8'd0);
      if (bus0.busy) n++;
      else break;
    end
    idleInputs();
    checkOutput({name, "_busy_cycles"}, 8'(n), 8'd16);
  endtask

  task automatic readAllZero(input string name);
    for (int a = 0; a < 16; a++) begin
      bus0.rd_en   = 1'b1;
      bus0.rd_addr = 4'(a);
      tick();
      checkOutput($sformatf("%s_data_%0d", name, a), bus0.rd_data, 8'h00);
      checkOutput($sformatf("%s_valid_%0d", name, a), {7'd0, bus0.rd_valid}, 8'd1);
    end
    idleInputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // wrEn a0 d0 m0 a1 d1 m1 rdEn rdAddr expValid expData expDataNb
    vecs[0]  = '{2'b01, 4'd3, 8'hAB, 8'hFF, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3, 1'b1, 8'hAB, 8'hAB};
    vecs[2]  = '{2'b01, 4'd5, 8'hF0, 8'hFF, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 8'hAB, 8'hAB};
    vecs[3]  = '{2'b11, 4'd5, 8'h0F, 8'h03, 4'd5, 8'hFF, 8'h01, 1'b0, 4'd0, 1'b0, 8'hAB, 8'hAB};
    vecs[4]  = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5, 1'b1, 8'hF3, 8'hF3};
    vecs[5]  = '{2'b01, 4'd2, 8'h11, 8'hFF, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 8'hF3, 8'hF3};
    vecs[6]  = '{2'b01, 4'd2, 8'h22, 8'hFF, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2, 1'b1, 8'h22, 8'h11};
    vecs[7]  = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2, 1'b1, 8'h22, 8'h22};
    vecs[8]  = '{2'b01, 4'd2, 8'hFF, 8'h00, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 8'h22, 8'h22};
    vecs[9]  = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2, 1'b1, 8'h22, 8'h22};
    vecs[10] = '{2'b11, 4'd7, 8'h55, 8'hFF, 4'd8, 8'hAA, 8'hFF, 1'b1, 4'd7, 1'b1, 8'h55, 8'h00};
    vecs[11] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd8, 1'b1, 8'hAA, 8'hAA};
    vecs[12] = '{2'b11, 4'd9, 8'h12, 8'hFF, 4'd9, 8'h34, 8'hF0, 1'b1, 4'd9, 1'b1, 8'h32, 8'h00};
    vecs[13] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd9, 1'b1, 8'h32, 8'h32};
    vecs[14] = '{2'b00, 4'd9, 8'hFF, 8'hFF, 4'd9, 8'hFF, 8'hFF, 1'b1, 4'd9, 1'b1, 8'h32, 8'h32};
    vecs[15] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b0, 4'd3, 1'b0, 8'h32, 8'h32};
    vecs[16] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b0, 4'd5, 1'b0, 8'h32, 8'h32};
    vecs[17] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3, 1'b1, 8'hAB, 8'hAB};
    vecs[18] = '{2'b10, 4'd0, 8'h00, 8'h00, 4'd3, 8'h00, 8'h0F, 1'b1, 4'd3, 1'b1, 8'hA0, 8'hAB};
    vecs[19] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3, 1'b1, 8'hA0, 8'hA0};

    idleInputs();
    rst = 1'b1;
    tick();
    checkOutput("reset_busy", {7'd0, bus0.busy}, 8'd1);
    checkOutput("reset_rdvalid", {7'd0, bus0.rd_valid}, 8'd0);
    checkOutput("reset_rddata", bus0.rd_data, 8'h00);
    rst = 1'b0;
    countBusy("init_sweep", 1'b1);
    readAllZero("init_read");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), {7'd0, bus0.rd_valid}, {7'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_data", i), bus0.rd_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d_valid_nb", i), {7'd0, bus1.rd_valid}, {7'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_data_nb", i), bus1.rd_data, vecs[i].expDataNb);
    end
    idleInputs();

    // Clear request alongside a write, then writes and reads hammered during the sweep.
    bus0.wr_en   = 2'b01;
    bus0.wr_addr = {4'd0, 4'd4};
    bus0.wr_data = {8'h00, 8'h77};
    bus0.wr_mask = {8'h00, 8'hFF};
    bus0.clr_req = 1'b1;
    tick();
    checkOutput("clr_busy_rise", {7'd0, bus0.busy}, 8'd1);
    bus0.clr_req = 1'b0;
    bus0.wr_addr = {4'd15, 4'd15};
    bus0.wr_data = 16'hFFFF;
    bus0.wr_mask = 16'hFFFF;
    bus0.wr_en   = 2'b11;
    bus0.rd_en   = 1'b1;
    bus0.rd_addr = 4'd15;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput($sformatf("sweep_busy_%0d", k), {7'd0, bus0.busy}, 8'd1);
      checkOutput($sformatf("sweep_rdvalid_%0d", k), {7'd0, bus0.rd_valid}, 8'd0);
      checkOutput($sformatf("sweep_rdhold_%0d", k), bus0.rd_data, 8'hA0);
    end

    // Reset lands with the sweep pointer at 7 and must restart the whole sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", {7'd0, bus0.busy}, 8'd1);
    checkOutput("midrst_rddata", bus0.rd_data, 8'h00);
    countBusy("restart_sweep", 1'b1);
    readAllZero("after_clear");

    // Read then idle with a moving address: valid drops, data is held.
    bus0.rd_en   = 1'b1;
    bus0.rd_addr = 4'd6;
    bus0.wr_en   = 2'b01;
    bus0.wr_addr = {4'd0, 4'd6};
    bus0.wr_data = {8'h00, 8'h5C};
    bus0.wr_mask = {8'h00, 8'hFF};
    tick();
    idleInputs();
    checkOutput("rd_then_idle_valid1", {7'd0, bus0.rd_valid}, 8'd1);
    checkOutput("rd_then_idle_data1", bus0.rd_data, 8'h5C);
    bus0.rd_addr = 4'd9;
    tick();
    checkOutput("rd_then_idle_valid0", {7'd0, bus0.rd_valid}, 8'd0);
    checkOutput("rd_then_idle_hold", bus0.rd_data, 8'h5C);
    checkOutput("rd_then_idle_hold_nb", bus1.rd_data, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
